// File: rtl/vram_pkg.sv
// ---------------------------------------------------------------------------
// vram_pkg : shared scan FSM state type and default VRAM geometry
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vram_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;
  localparam int FIFO_D = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } scan_state_e;
endpackage

`default_nettype wire

// File: rtl/vram_scan_fifo.sv
// ---------------------------------------------------------------------------
// vram_scan_fifo : synchronous FIFO buffering scan words for the consumer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vram_scan_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             w_push;
  logic             w_pop;

  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head is masked to zero when empty so the output reads 0 out of reset.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
endmodule

`default_nettype wire

// File: rtl/vram_scan.sv
// ---------------------------------------------------------------------------
// vram_scan : dual-port VRAM with pipelined CPU port and burst scan-out;
//             define VRAM_BYTEWR_EN to honour cpu_be on writes. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vram_scan #(
  parameter int DATA_W = vram_pkg::DATA_W,
  parameter int ADDR_W = vram_pkg::ADDR_W,
  parameter int FIFO_D = vram_pkg::FIFO_D
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W/8-1:0] cpu_be,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_ack,
  output logic [DATA_W-1:0]   cpu_rdata,
  input  logic                scan_start,
  input  logic [ADDR_W-1:0]   scan_base,
  input  logic [ADDR_W:0]     scan_len,
  input  logic                scan_ready,
  output logic                scan_valid,
  output logic [DATA_W-1:0]   scan_data,
  output logic                scan_busy,
  output logic                scan_done
);
  import vram_pkg::*;

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(FIFO_D) + 1;
  localparam logic [CNT_W:0] FIFO_D_L = (CNT_W+1)'(FIFO_D);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] ram_a_q;
  logic [DATA_W-1:0] ram_b_q;
  logic [BE_W-1:0]   w_be;

`ifdef VRAM_BYTEWR_EN
  assign w_be = cpu_be;
`else
  logic w_unused_be;
  assign w_be        = '1;
  assign w_unused_be = ^cpu_be;
`endif

  // Port A: CPU, read-first so a read sees the word before this cycle's write.
  always_ff @(posedge clk) begin
    if (cpu_req && !reset) begin
      ram_a_q <= mem_q[cpu_addr];
      if (cpu_we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (w_be[b]) mem_q[cpu_addr][b*8 +: 8] <= cpu_wdata[b*8 +: 8];
        end
      end
    end
  end

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              issue_p1_q;
  logic              zdone_q;
  logic              w_issue;
  logic              w_zero_done;

  // Port B: scan read, issued one word per cycle from the burst address.
  always_ff @(posedge clk) begin
    if (w_issue) ram_b_q <= mem_q[addr_q];
  end

  logic req_p1_q;
  logic rd_p1_q;
  logic ack_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_p1_q <= 1'b0;
      rd_p1_q  <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      req_p1_q <= cpu_req;
      rd_p1_q  <= cpu_req & ~cpu_we;
      ack_q    <= req_p1_q;
      if (rd_p1_q) rdata_q <= ram_a_q;
    end
  end

  // An ack already in the output register is suppressed while reset is high.
  assign cpu_ack   = ack_q & ~reset;
  assign cpu_rdata = rdata_q;

  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_pop;
  logic [CNT_W:0]   w_pending;
  logic             w_room;
  logic             w_last_xfer;

  vram_scan_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (issue_p1_q),
    .pop_i   (w_pop),
    .data_i  (ram_b_q),
    .data_o  (scan_data),
    .count_o (w_fifo_count),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign scan_valid = ~w_fifo_empty;
  assign w_pop      = scan_valid & scan_ready;
  // Reads in flight are reserved FIFO slots, so issue never overruns the buffer.
  assign w_pending  = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, issue_p1_q};
  assign w_room     = ~w_fifo_full & (w_pending < FIFO_D_L);
  assign w_last_xfer = (state_q == DRAIN) & w_pop & ~issue_p1_q &
                       (w_fifo_count == CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    w_issue     = 1'b0;
    w_zero_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan_start) begin
          if (scan_len != '0) begin
            state_d = RUN;
            addr_d  = scan_base;
            rem_d   = scan_len;
          end else begin
            w_zero_done = 1'b1;
          end
        end
      end
      RUN: begin
        if (w_room) begin
          w_issue = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          if (rem_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (w_last_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      issue_p1_q <= 1'b0;
      zdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      issue_p1_q <= w_issue;
      zdone_q    <= w_zero_done;
    end
  end

  assign scan_busy = (state_q != IDLE);
  assign scan_done = ~reset & (zdone_q | w_last_xfer);
endmodule

`default_nettype wire

// File: tb/tb_vram_scan.sv
// ---------------------------------------------------------------------------
// tb_vram_scan : scoreboard bench for vram_scan (CPU port and scan bursts)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vram_scan;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        scan_start;
  logic [12:0] scan_base;
  logic [13:0] scan_len;
  logic        scan_ready;
  logic        scan_valid;
  logic [31:0] scan_data;
  logic        scan_busy;
  logic        scan_done;

  vram_scan dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len),
    .scan_ready(scan_ready), .scan_valid(scan_valid), .scan_data(scan_data),
    .scan_busy(scan_busy), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; bit rd; logic [31:0] data; } cpu_exp_t;
  typedef struct { logic [31:0] data; bit last; } scan_exp_t;

  cpu_exp_t    cq[$];
  scan_exp_t   sq[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          zdone_cyc = -1;
  logic [31:0] last_rd = 32'h0;
  logic [31:0] pat = 32'hB2E5_38D6;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents them.
  always @(negedge clk) begin
    bit xfer_last;
    if (cq.size() != 0 && cq[0].cyc == cyc) begin
      chk("cpu_ack", {31'h0, cpu_ack}, 32'd1);
      if (cq[0].rd) begin
        chk("cpu_rdata", cpu_rdata, cq[0].data);
        last_rd = cq[0].data;
      end
      void'(cq.pop_front());
    end else begin
      chk("cpu_ack_idle", {31'h0, cpu_ack}, 32'd0);
      if (!reset) chk("cpu_rdata_hold", cpu_rdata, last_rd);
    end
    if (!reset) begin
      xfer_last = 1'b0;
      if (sq.size() != 0) begin
        if (scan_valid) begin
          chk("scan_data", scan_data, sq[0].data);
          if (scan_ready) begin
            xfer_last = sq[0].last;
            void'(sq.pop_front());
          end
        end
      end else begin
        chk("scan_valid_idle", {31'h0, scan_valid}, 32'd0);
      end
      chk("scan_done", {31'h0, scan_done}, {31'h0, (xfer_last || cyc == zdone_cyc)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_be = be; cpu_wdata = d;
    cq.push_back('{cyc: cyc + 2, rd: 1'b0, data: 32'h0});
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [12:0] a, input logic [31:0] exp);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    cq.push_back('{cyc: cyc + 2, rd: 1'b1, data: exp});
    step();
    cpu_req = 1'b0;
  endtask

  task automatic scan_go(input logic [12:0] base, input logic [13:0] len);
    scan_start = 1'b1; scan_base = base; scan_len = len;
    step();
    scan_start = 1'b0;
  endtask

  task automatic wait_cpu(input int budget);
    int n = 0;
    while (cq.size() != 0 && n < budget) begin step(); n++; end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL cpu_timeout: pending=%0d required=0", cq.size());
    end
  endtask

  task automatic wait_scan(input bit rnd, input int budget);
    int n = 0;
    while ((sq.size() != 0 || scan_busy) && n < budget) begin
      if (rnd) scan_ready = pat[n % 32];
      step();
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL scan_timeout: pending=%0d required=0", sq.size());
    end
    scan_ready = 1'b1;
  endtask

  task automatic push_wrap_burst();
    sq.push_back('{data: 32'hCAFE_1FFE, last: 1'b0});
    sq.push_back('{data: 32'hCAFE_1FFF, last: 1'b0});
    sq.push_back('{data: 32'hCAFE_0000, last: 1'b0});
    sq.push_back('{data: 32'hCAFE_0001, last: 1'b1});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] be_exp;
`ifdef VRAM_BYTEWR_EN
    be_exp = 32'hDEAD_5678;
`else
    be_exp = 32'h1234_5678;
`endif
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0;
    cpu_wdata = '0; scan_start = 1'b0; scan_base = '0; scan_len = '0; scan_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cpu_ack",   {31'h0, cpu_ack}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_scan_valid",{31'h0, scan_valid}, 32'd0);
    chk("rst_scan_data", scan_data, 32'h0);
    chk("rst_scan_busy", {31'h0, scan_busy}, 32'd0);
    chk("rst_scan_done", {31'h0, scan_done}, 32'd0);
    step();

    // CPU write/read and byte enables
    cpu_wr(13'h0010, 32'hDEAD_BEEF, 4'hF);
    cpu_rd(13'h0010, 32'hDEAD_BEEF);
    cpu_wr(13'h0010, 32'h1234_5678, 4'b0011);
    cpu_rd(13'h0010, be_exp);
    cpu_wr(13'h1FFE, 32'hCAFE_1FFE, 4'hF);
    cpu_wr(13'h1FFF, 32'hCAFE_1FFF, 4'hF);
    cpu_wr(13'h0000, 32'hCAFE_0000, 4'hF);
    cpu_wr(13'h0001, 32'hCAFE_0001, 4'hF);
    cpu_rd(13'h1FFF, 32'hCAFE_1FFF);
    cpu_rd(13'h0000, 32'hCAFE_0000);
    for (int i = 0; i < 16; i++) cpu_wr(13'h0100 + 13'(i), 32'h5A5A_0000 + i, 4'hF);
    cpu_wr(13'h0020, 32'h1111_1111, 4'hF);
    wait_cpu(20);

    // Wrapping burst, consumer always ready
    scan_ready = 1'b1;
    push_wrap_burst();
    scan_go(13'h1FFE, 14'd4);
    @(negedge clk);
    chk("scan_busy_run", {31'h0, scan_busy}, 32'd1);
    step();
    wait_scan(1'b0, 40);

    // 16-word burst with irregular ready; a start while busy must be ignored
    for (int i = 0; i < 16; i++) sq.push_back('{data: 32'h5A5A_0000 + i, last: (i == 15)});
    scan_ready = 1'b0;
    scan_go(13'h0100, 14'd16);
    scan_start = 1'b1; scan_base = 13'h0000; scan_len = 14'd4;
    step();
    scan_start = 1'b0;
    wait_scan(1'b1, 400);

    // Zero-length start
    scan_ready = 1'b1;
    zdone_cyc = cyc + 1;
    scan_go(13'h0100, 14'd0);
    @(negedge clk);
    chk("zero_busy0",  {31'h0, scan_busy}, 32'd0);
    chk("zero_valid0", {31'h0, scan_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("zero_busy1",  {31'h0, scan_busy}, 32'd0);
    chk("zero_valid1", {31'h0, scan_valid}, 32'd0);
    step();

    // Scan read and CPU write hit the same word in the same cycle
    sq.push_back('{data: 32'h1111_1111, last: 1'b1});
    scan_go(13'h0020, 14'd1);
    cpu_wr(13'h0020, 32'h2222_2222, 4'hF);
    cpu_rd(13'h0020, 32'h2222_2222);
    wait_cpu(20);
    wait_scan(1'b0, 40);

    // Reset mid-burst; CPU reads in the two cycles before reset get no ack
    for (int i = 0; i < 16; i++) sq.push_back('{data: 32'h5A5A_0000 + i, last: (i == 15)});
    scan_ready = 1'b0;
    scan_go(13'h0100, 14'd16);
    repeat (6) step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    step();
    step();
    cpu_req = 1'b0;
    reset = 1'b1;
    sq.delete();
    last_rd = 32'h0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy",  {31'h0, scan_busy}, 32'd0);
    chk("mid_rst_valid", {31'h0, scan_valid}, 32'd0);
    chk("mid_rst_done",  {31'h0, scan_done}, 32'd0);
    step();

    // New burst after reset; RAM contents survive reset
    scan_ready = 1'b1;
    push_wrap_burst();
    scan_go(13'h1FFE, 14'd4);
    wait_scan(1'b0, 40);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
